mpc_input_driver: RTL and testbench

MPC_INPUT_DRIVER -- requirements
Module: mpc_input_driver

---
 rtl/mpc_input_driver.sv | 191 +++++++++++++++++++
 tb/tb_mpc_input_driver.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpc_input_driver.sv
// ---------------------------------------------------------------------------
// mpc_input_driver
//
// Feeds the two parties' input words to a garbled-circuit / MPC evaluator one
// input wire at a time. Then it waits for the single-bit circuit output, with
// a bounded timeout, and hands the result to the host.
//
// Wire order: x[0..WIDTH-1] on wires 0..WIDTH-1, then y[0..WIDTH-1] on wires
// WIDTH..2*WIDTH-1. The shift register holds {y, x} and is shifted right on
// each accepted bit, so bit 0 is always the wire being presented.
//
// Ports
//   clk          in   1       sole clock, rising edge
//   rst_n        in   1       synchronous active-low reset
//   req_valid    in   1       request (party words) present
//   req_ready    out  1       driver can accept a request (IDLE)
//   req_x        in   WIDTH   party-A word, circuit input x
//   req_y        in   WIDTH   party-B word, circuit input y
//   bit_valid    out  1       input-wire bit presented to evaluator
//   bit_ready    in   1       evaluator accepts bit
//   bit_data     out  1       input-wire value
//   bit_wire     out  WIRE_W  input-wire index
//   bit_last     out  1       final input wire of the request
//   res_valid    in   1       evaluator result strobe (single cycle)
//   res_data     in   1       evaluator circuit output bit
//   out_valid    out  1       result available to host
//   out_ready    in   1       host accepts result
//   out_result   out  1       circuit output (0 on timeout)
//   out_timeout  out  1       result was produced by timeout
//   busy         out  1       state other than IDLE
//
// States
//   state | meaning
//   IDLE  | ready for a new request
//   SEND  | presenting input-wire bits to the evaluator
//   WAIT  | all bits sent, waiting for res_valid or timeout
//   RESP  | holding the result until the host takes it
// ---------------------------------------------------------------------------
module mpc_input_driver #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1024,
    localparam int WIRE_W = $clog2(2 * WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WIDTH-1:0]  req_x,
    input  logic [WIDTH-1:0]  req_y,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic              bit_data,
    output logic [WIRE_W-1:0] bit_wire,
    output logic              bit_last,
    input  logic              res_valid,
    input  logic              res_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_result,
    output logic              out_timeout,
    output logic              busy
);

    localparam int SR_W  = 2 * WIDTH;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [WIRE_W-1:0] LAST_WIRE = WIRE_W'(SR_W - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t            state_q,   state_d;
    logic [SR_W-1:0]   shift_q,   shift_d;
    logic [WIRE_W-1:0] cnt_q,     cnt_d;
    logic [TMR_W-1:0]  tmr_q,     tmr_d;
    logic              result_q,  result_d;
    logic              timeout_q, timeout_d;

    logic in_idle;
    logic in_send;
    logic in_resp;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            tmr_q     <= '0;
            result_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        result_d  = result_q;
        timeout_d = timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    shift_d = {req_y, req_x};
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                if (bit_ready) begin
                    shift_d = shift_q >> 1;
                    // The counter parks on the last wire instead of wrapping.
                    // The next request clears it.
                    if (cnt_q == LAST_WIRE) begin
                        tmr_d   = '0;
                        state_d = ST_WAIT;
                    end else begin
                        cnt_d = cnt_q + WIRE_W'(1);
                    end
                end
            end

            ST_WAIT: begin
                // A result arriving on the expiry cycle still counts as a
                // real result, so res_valid is tested before the timer.
                if (res_valid) begin
                    result_d  = res_data;
                    timeout_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (tmr_q == TMR_LAST) begin
                    result_d  = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            ST_RESP: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Handshake outputs are also qualified with rst_n. This keeps them at
    // zero for the whole time reset is asserted, including the part of the
    // first reset cycle before the synchronous reset has taken effect.
    assign in_idle = rst_n && (state_q == ST_IDLE);
    assign in_send = rst_n && (state_q == ST_SEND);
    assign in_resp = rst_n && (state_q == ST_RESP);

    assign req_ready   = in_idle;
    assign bit_valid   = in_send;
    assign bit_data    = in_send && shift_q[0];
    assign bit_wire    = in_send ? cnt_q : '0;
    assign bit_last    = in_send && (cnt_q == LAST_WIRE);
    assign out_valid   = in_resp;
    assign out_result  = result_q;
    assign out_timeout = timeout_q;
    assign busy        = rst_n && (state_q != ST_IDLE);

endmodule

// File: tb/tb_mpc_input_driver.sv
// ---------------------------------------------------------------------------
// tb_mpc_input_driver
//
// Directed bench for mpc_input_driver (WIDTH=32, short TIMEOUT).
// A table of whole requests is run back-to-back. Each record gives the party
// words, the bit_ready pattern, when the evaluator answers and the expected
// result. Hand-written sequences cover reset, stray res_valid and a reset
// that arrives in the middle of a request.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mpc_input_driver;

    localparam int W  = 32;
    localparam int TO = 20;
    localparam int WW = $clog2(2 * W + 1);

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [W-1:0]  req_x;
    logic [W-1:0]  req_y;
    logic          bit_valid;
    logic          bit_ready;
    logic          bit_data;
    logic [WW-1:0] bit_wire;
    logic          bit_last;
    logic          res_valid;
    logic          res_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_result;
    logic          out_timeout;
    logic          busy;

    int checks = 0;
    int errors = 0;

    mpc_input_driver #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .bit_data   (bit_data),
        .bit_wire   (bit_wire),
        .bit_last   (bit_last),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_timeout(out_timeout),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required $finish");
        $fatal(1, "watchdog");
    end

    // mode: 0 = bit_ready held high, 1 = bit_ready toggles 1-0-1
    // d:    WAIT cycle on which res_valid is pulsed, -1 = never
    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           mode;
        int           d;
        logic         rd;
        logic         exp_res;
        logic         exp_to;
        int           exp_wait;
        int           hold;
    } txn_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag, input bit regs_too);
        chk({tag, ":req_ready"}, 64'(req_ready), 0);
        chk({tag, ":bit_valid"}, 64'(bit_valid), 0);
        chk({tag, ":bit_data"},  64'(bit_data),  0);
        chk({tag, ":bit_wire"},  64'(bit_wire),  0);
        chk({tag, ":bit_last"},  64'(bit_last),  0);
        chk({tag, ":out_valid"}, 64'(out_valid), 0);
        chk({tag, ":busy"},      64'(busy),      0);
        if (regs_too) begin
            chk({tag, ":out_result"},  64'(out_result),  0);
            chk({tag, ":out_timeout"}, 64'(out_timeout), 0);
        end
    endtask

    task automatic start_req(input logic [W-1:0] x, input logic [W-1:0] y);
        chk("idle:req_ready", 64'(req_ready), 1);
        chk("idle:busy", 64'(busy), 0);
        req_valid = 1'b1;
        req_x     = x;
        req_y     = y;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [W-1:0] x, input logic [W-1:0] y, input int mode);
        logic [2*W-1:0] m;
        int idx;
        int cyc;
        m   = {y, x};
        idx = 0;
        cyc = 0;
        while (idx < 2 * W && cyc < 400) begin
            chk($sformatf("send:bit_valid@%0d", idx), 64'(bit_valid), 1);
            chk($sformatf("send:bit_wire@%0d", idx),  64'(bit_wire), 64'(idx));
            chk($sformatf("send:bit_data@%0d", idx),  64'(bit_data), 64'(m[idx]));
            chk($sformatf("send:bit_last@%0d", idx),  64'(bit_last), 64'(idx == 2 * W - 1));
            chk($sformatf("send:req_ready@%0d", idx), 64'(req_ready), 0);
            bit_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            @(negedge clk);
            if (bit_ready) idx++;
            cyc++;
        end
        bit_ready = 1'b0;
        chk("send:transfers", 64'(idx), 64'(2 * W));
        chk("send_done:bit_valid", 64'(bit_valid), 0);
        chk("send_done:busy", 64'(busy), 1);
    endtask

    task automatic wait_res(input int d, input logic rd, input logic er, input logic et, input int ew);
        int k;
        k = 0;
        while (out_valid !== 1'b1 && k < TO + 10) begin
            res_valid = (k == d);
            res_data  = rd;
            @(negedge clk);
            res_valid = 1'b0;
            k++;
        end
        chk("wait:cycles", 64'(k), 64'(ew));
        chk("resp:out_valid", 64'(out_valid), 1);
        chk("resp:out_result", 64'(out_result), 64'(er));
        chk("resp:out_timeout", 64'(out_timeout), 64'(et));
        chk("resp:req_ready", 64'(req_ready), 0);
        chk("resp:busy", 64'(busy), 1);
    endtask

    task automatic take_out(input int hold, input logic er, input logic et);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            @(negedge clk);
            chk($sformatf("hold%0d:out_valid", i),   64'(out_valid), 1);
            chk($sformatf("hold%0d:out_result", i),  64'(out_result), 64'(er));
            chk($sformatf("hold%0d:out_timeout", i), 64'(out_timeout), 64'(et));
            chk($sformatf("hold%0d:req_ready", i),   64'(req_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("taken:out_valid", 64'(out_valid), 0);
        chk("taken:req_ready", 64'(req_ready), 1);
        chk("taken:busy", 64'(busy), 0);
    endtask

    txn_t tbl [5];

    initial begin
        //               x             y             mode d       rd    res   to    wait    hold
        tbl[0] = '{32'd9001,      32'd1337,      0,   0,      1'b1, 1'b1, 1'b0, 1,      0};
        tbl[1] = '{32'd9001,      32'd1337,      1,   3,      1'b0, 1'b0, 1'b0, 4,      2};
        tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 0,   -1,     1'b1, 1'b0, 1'b1, TO,     5};
        tbl[3] = '{32'h0000_0000, 32'hFFFF_FFFF, 1,   TO - 1, 1'b1, 1'b1, 1'b0, TO,     0};
        tbl[4] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 0,   TO - 2, 1'b1, 1'b1, 1'b0, TO - 1, 1};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_x     = '0;
        req_y     = '0;
        bit_ready = 1'b0;
        res_valid = 1'b0;
        res_data  = 1'b0;
        out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk_zero("reset1", 1'b1);
        @(negedge clk);
        chk_zero("reset2", 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset:req_ready", 64'(req_ready), 1);
        chk("post_reset:busy", 64'(busy), 0);

        // Stray res_valid in IDLE
        res_valid = 1'b1;
        res_data  = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        res_data  = 1'b0;
        chk("stray_idle:req_ready", 64'(req_ready), 1);
        chk("stray_idle:busy", 64'(busy), 0);
        chk("stray_idle:out_valid", 64'(out_valid), 0);
        chk("stray_idle:bit_valid", 64'(bit_valid), 0);

        // Table of back-to-back requests
        foreach (tbl[i]) begin
            start_req(tbl[i].x, tbl[i].y);
            send_bits(tbl[i].x, tbl[i].y, tbl[i].mode);
            wait_res(tbl[i].d, tbl[i].rd, tbl[i].exp_res, tbl[i].exp_to, tbl[i].exp_wait);
            take_out(tbl[i].hold, tbl[i].exp_res, tbl[i].exp_to);
        end

        // Stray res_valid during SEND. It must not be captured, so the
        // request later ends in a timeout with result 0.
        start_req(32'h1234_5678, 32'h0F0F_F0F0);
        bit_ready = 1'b0;
        res_valid = 1'b1;
        res_data  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("stray_send%0d:bit_valid", i), 64'(bit_valid), 1);
            chk($sformatf("stray_send%0d:bit_wire", i),  64'(bit_wire), 0);
            chk($sformatf("stray_send%0d:out_valid", i), 64'(out_valid), 0);
            chk($sformatf("stray_send%0d:busy", i),      64'(busy), 1);
        end
        res_valid = 1'b0;
        res_data  = 1'b0;
        send_bits(32'h1234_5678, 32'h0F0F_F0F0, 0);
        wait_res(-1, 1'b0, 1'b0, 1'b1, TO);
        take_out(0, 1'b0, 1'b1);

        // Reset while wire 20 is presented, then restart with x=1, y=0
        start_req(32'hDEAD_BEEF, 32'hCAFE_F00D);
        bit_ready = 1'b1;
        for (int i = 0; i < 40 && bit_wire != WW'(20); i++) @(negedge clk);
        chk("mid_send:bit_wire", 64'(bit_wire), 20);
        rst_n     = 1'b0;
        bit_ready = 1'b0;
        #1;
        chk_zero("rst_low", 1'b0);
        @(negedge clk);
        chk_zero("rst_edge", 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release:req_ready", 64'(req_ready), 1);
        chk("rst_release:bit_valid", 64'(bit_valid), 0);
        chk("rst_release:out_valid", 64'(out_valid), 0);
        start_req(32'd1, 32'd0);
        chk("restart:bit_wire", 64'(bit_wire), 0);
        chk("restart:bit_data", 64'(bit_data), 1);
        send_bits(32'd1, 32'd0, 0);
        wait_res(0, 1'b0, 1'b0, 1'b0, 1);
        take_out(0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
